// File: rtl/hidden_layer_seq.sv
// One fully connected layer evaluated on a single shared signed MAC.
// Walks input/weight memories, adds bias, applies a saturating ReLU, writes one result per neuron.
module hidden_layer_seq #(
    parameter int N_IN  = 10,
    parameter int N_OUT = 5,
    parameter int DW    = 10,
    parameter int FRAC  = 0,
    localparam int IAW  = (N_IN  > 1) ? $clog2(N_IN)  : 1,
    localparam int WAW  = $clog2(N_OUT * (N_IN + 1)),
    localparam int OAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [IAW-1:0]       in_addr,
    input  logic signed [DW-1:0] in_data,
    output logic [WAW-1:0]       w_addr,
    input  logic signed [DW-1:0] w_data,
    output logic                 out_we,
    output logic [OAW-1:0]       out_addr,
    output logic [DW-1:0]        out_data,
    output logic                 busy,
    output logic                 done
);
    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | issue input/weight address i, accumulate product returned from issue i-1
    // DRAIN  | accumulate the bias word returned from the last issue
    // WRITE  | present activated result for neuron j
    // DONE   | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

    localparam int CW   = $clog2(N_IN + 1);
    localparam int ACCW = 2 * DW + $clog2(N_IN + 1) + 1;
    localparam logic signed [ACCW-1:0] SMAX = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic [DW-1:0]          OMAX = DW'((2 ** (DW - 1)) - 1);

    state_t                 state;
    logic [CW-1:0]          idx;
    logic [OAW-1:0]         neuron;
    logic signed [ACCW-1:0] acc;
    logic                   weReg;
    logic                   doneReg;

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] prodExt;
    logic signed [ACCW-1:0] biasExt;
    logic signed [ACCW-1:0] accWithBias;

    assign prod        = in_data * w_data;
    assign prodExt     = ACCW'(prod);
    assign biasExt     = ACCW'(w_data) <<< FRAC;
    assign accWithBias = acc + biasExt;

    // abort cancels a strobe that would otherwise be visible in the same cycle
    assign out_we = weReg & ~abort;
    assign done   = doneReg & ~abort;

    function automatic logic [DW-1:0] relu(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] s;
        s = a >>> FRAC;
        if (s[ACCW-1])     relu = '0;
        else if (s > SMAX) relu = OMAX;
        else               relu = s[DW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            neuron   <= '0;
            acc      <= '0;
            weReg    <= 1'b0;
            doneReg  <= 1'b0;
            busy     <= 1'b0;
            in_addr  <= '0;
            w_addr   <= '0;
            out_addr <= '0;
            out_data <= '0;
        end else if (state != IDLE && abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            weReg   <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        idx     <= '0;
                        neuron  <= '0;
                        acc     <= '0;
                        in_addr <= '0;
                        w_addr  <= '0;
                    end
                end
                FETCH: begin
                    if (idx != '0) acc <= acc + prodExt;
                    if (idx == CW'(N_IN)) begin
                        state <= DRAIN;
                    end else begin
                        idx    <= idx + 1'b1;
                        w_addr <= w_addr + 1'b1;
                        // the bias issue keeps the last input address on the bus
                        if (idx < CW'(N_IN - 1)) in_addr <= IAW'(idx + 1'b1);
                    end
                end
                DRAIN: begin
                    acc      <= accWithBias;
                    out_data <= relu(accWithBias);
                    out_addr <= neuron;
                    weReg    <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    weReg   <= 1'b0;
                    acc     <= '0;
                    idx     <= '0;
                    in_addr <= '0;
                    if (neuron == OAW'(N_OUT - 1)) begin
                        doneReg <= 1'b1;
                        state   <= DONE;
                    end else begin
                        neuron <= neuron + 1'b1;
                        w_addr <= w_addr + 1'b1;
                        state  <= FETCH;
                    end
                end
                DONE: begin
                    doneReg <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/hidden_layer_seq.md
Name: hidden_layer_seq

Overview:
- Sequencer for one fully connected neural-network layer. A single shared signed MAC is time-multiplexed across N_OUT neurons.
- Walks input and weight memories in a fixed order, accumulates dot product plus bias, applies ReLU with saturation, and writes each neuron result to the layer output buffer.
- Instantiated once per layer (hidden, output); chained by connecting done of one layer to start of the next.

Parameters:
- N_IN, 10, inputs per neuron
- N_OUT, 5, neurons in layer
- DW, 10, signed two's-complement data/weight width
- FRAC, 0, fractional bits of the fixed-point format (bias is multiplied by 1<<FRAC)

Ports:
- Clock  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to evaluate the layer; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE next cycle, no done
- in_addr  out  clog2(N_IN)  input-vector read address
- in_data  in  DW  input word; valid 1 cycle after in_addr (registered-read memory)
- w_addr  out  clog2(N_OUT*(N_IN+1))  weight read address
- w_data  in  DW  weight word; valid 1 cycle after w_addr
- out_we  out  1  result write strobe, 1 cycle per neuron
- out_addr  out  clog2(N_OUT)  neuron index of result
- out_data  out  DW  activated result
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after last write

Behaviour:
- Reset (Rst=0, async): state=IDLE; busy, done, out_we=0; all addresses, out_data, acc, and counters=0.
- Weight layout: w_addr = j*(N_IN+1)+i. Index i=N_IN is bias b[j]. Bias term = b[j]<<FRAC, with no in_data read.
- States:
  - IDLE: start=1 -> FETCH, with j=0, i=0, acc=0.
  - FETCH: drive in_addr=i (held at N_IN-1 for bias cycle) and w_addr. Product of data returned this cycle from the previous issue is added to acc. i increments; after issuing i=N_IN -> DRAIN.
  - DRAIN: add last (bias) term.
  - WRITE: out_we=1, out_addr=j, out_data=act(acc). Then acc=0, i=0. If j==N_OUT-1 -> DONE, else j++ and -> FETCH.
  - DONE: done=1 for 1 cycle -> IDLE.
- Timing:
  - Per neuron: N_IN+3 cycles.
  - Start-accepting edge to done-high cycle: N_OUT*(N_IN+3)+1 cycles (66 at defaults).
  - busy high in FETCH, DRAIN, WRITE, and DONE.
- Arithmetic:
  - Product is signed 2*DW bits.
  - acc is signed 2*DW+clog2(N_IN+1)+1 bits, so it cannot overflow.
  - act(acc) is computed on s = acc >>> FRAC (arithmetic shift): s<0 -> 0; s > 2^(DW-1)-1 -> 2^(DW-1)-1 (511); else s.
- Boundaries:
  - start while busy: ignored, no restart.
  - start in the DONE cycle: ignored.
  - abort in any non-IDLE state: next state IDLE, busy=0. A pending out_we in that same cycle is suppressed. No done pulse.
  - abort and start both high in IDLE: abort wins; stay IDLE.
  - Rst mid-operation: immediate return to reset values. A partial layer is never resumed.
  - out_data holds its last written value between writes. Output is valid only when qualified by out_we.
  - Memories are read-only to this block. Weight loading is outside its scope.

Test Plan:
- All in_data=1, weights=1, bias=0; start -> out_we at addr 0..4 with data 10 each, every 13 cycles; done exactly 66 cycles after start edge; busy low after done.
- x=1, w=-2, bias=5 -> sum -15 -> out_data 0 for all neurons (ReLU); x=1, w=0, bias=7 -> out_data 7.
- x=100, w=100 -> 100000 clamps to out_data 511; x=-100, w=-100 -> also 511 (sign handled).
- Address trace check: neuron 2 issues w_addr 22..32 in order with in_addr 0..9; bias read at 32. Memory model returns data 1 cycle late; results must match a golden model.
- Second start pulse at cycle 20 of a run -> ignored, still 5 writes, single done. abort at cycle 30 -> busy=0 next cycle, no further out_we, no done; a following start runs a full clean layer.
- Rst low at cycle 40 -> all outputs 0 asynchronously. After release, start -> full 66-cycle run with correct results (acc not carried over).
